// File: rtl/mem_stage_dport_pkg.sv
// Shared rv32i type and constant definitions used by the MEM-stage data port.
package rv32i_types;

    // Data-port sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dport_state_t;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Byte-enable masks before lane shifting
    localparam logic [3:0] MBE_B  = 4'b0001;
    localparam logic [3:0] MBE_H  = 4'b0011;
    localparam logic [3:0] MBE_W  = 4'b1111;

    // Halfword access on an odd byte, or word access off a word boundary
    function automatic logic is_misaligned(input logic       is_read,
                                           input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic half;
        logic word;
        half = (funct3 == F3_LH) || (is_read && (funct3 == F3_LHU));
        word = (funct3 == F3_LW);
        return (half && offset[0]) || (word && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_dport_load_align.sv
// Load data extraction: picks the byte/halfword addressed by the latched offset
// out of the returned word and sign- or zero-extends it according to funct3.
module dport_load_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path first, otherwise a latch is inferred.
        byte_sel = rdata[7:0];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        data     = rdata;
        case (offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = rdata;  // LW and undefined encodings return the raw word
        endcase
    end

endmodule

// File: rtl/mem_stage_dport.sv
// MEM-stage data-memory initiator for the rv32i pipeline. Issues one read or
// write per load/store, stalls the pipeline until the one-cycle response pulse,
// then presents aligned load data for one DONE cycle.
// Optional performance counters: define MEM_STAGE_DPORT_PERF_CNT_EN.
module mem_stage_dport
    import rv32i_types::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic [2:0]       funct3_i,
    input  logic [width-1:0] addr_i,
    input  logic [width-1:0] store_data_i,
    output logic [width-1:0] dmem_address_o,
    output logic             dmem_read_o,
    output logic             dmem_write_o,
    output logic [3:0]       dmem_mbe_o,
    output logic [width-1:0] dmem_wdata_o,
    input  logic [width-1:0] dmem_rdata_i,
    input  logic             dmem_resp_i,
    output logic             stall_o,
    output logic [width-1:0] load_data_o,
    output logic             misalign_o,
    output logic [31:0]      load_cnt_o,
    output logic [31:0]      store_cnt_o,
    output logic [31:0]      stall_cnt_o
);

    dport_state_t     state;
    logic             active;
    logic [2:0]       funct3_q;
    logic [1:0]       offset_q;
    logic             is_read_q;
    logic [width-1:0] rdata_q;
    logic [3:0]       st_mbe;
    logic [width-1:0] st_wdata;

    assign active = req_valid_i & (mem_read_i | mem_write_i);

    // Store lane placement from the live request
    always_comb begin
        st_mbe   = MBE_W;
        st_wdata = store_data_i;
        case (funct3_i)
            F3_SB: begin
                st_mbe   = MBE_B << addr_i[1:0];
                st_wdata = {4{store_data_i[7:0]}};
            end
            F3_SH: begin
                st_mbe   = MBE_H << {addr_i[1], 1'b0};
                st_wdata = {2{store_data_i[15:0]}};
            end
            default: begin
                st_mbe   = MBE_W;
                st_wdata = store_data_i;
            end
        endcase
    end

    // Request sequencer: latch in IDLE, hold in BUSY, single DONE cycle
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state          <= IDLE;
            dmem_address_o <= '0;
            dmem_read_o    <= 1'b0;
            dmem_write_o   <= 1'b0;
            dmem_mbe_o     <= '0;
            dmem_wdata_o   <= '0;
            funct3_q       <= '0;
            offset_q       <= '0;
            is_read_q      <= 1'b0;
            rdata_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (active) begin
                        dmem_address_o <= {addr_i[width-1:2], 2'b00};
                        funct3_q       <= funct3_i;
                        offset_q       <= addr_i[1:0];
                        is_read_q      <= mem_read_i;
                        // A load wins when both read and write are flagged
                        if (mem_read_i) begin
                            dmem_read_o  <= 1'b1;
                            dmem_write_o <= 1'b0;
                            dmem_mbe_o   <= MBE_W;
                            dmem_wdata_o <= '0;
                        end else begin
                            dmem_read_o  <= 1'b0;
                            dmem_write_o <= 1'b1;
                            dmem_mbe_o   <= st_mbe;
                            dmem_wdata_o <= st_wdata;
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem_resp_i) begin
                        rdata_q      <= dmem_rdata_i;
                        dmem_read_o  <= 1'b0;
                        dmem_write_o <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Pipeline stall: combinational in IDLE so the issuing cycle is frozen too
    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:    stall_o = active;
            BUSY:    stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    dport_load_align u_load_align (
        .rdata  (rdata_q),
        .funct3 (funct3_q),
        .offset (offset_q),
        .data   (load_data_o)
    );

    assign misalign_o = is_misaligned(is_read_q, funct3_q, offset_q);

`ifdef MEM_STAGE_DPORT_PERF_CNT_EN
    logic [31:0] load_cnt_q;
    logic [31:0] store_cnt_q;
    logic [31:0] stall_cnt_q;

    // Wrapping event counters; loads/stores count on the BUSY->DONE transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if ((state == BUSY) && dmem_resp_i) begin
                if (is_read_q) load_cnt_q  <= load_cnt_q + 32'd1;
                else           store_cnt_q <= store_cnt_q + 32'd1;
            end
            if (stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign load_cnt_o  = load_cnt_q;
    assign store_cnt_o = store_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign load_cnt_o  = '0;
    assign store_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_stage_dport.sv
// Directed testbench for mem_stage_dport: loads, stores, alignment,
// misalignment, async reset in BUSY, ignored responses and counters.
module tb_mem_stage_dport;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] store_data_i = 32'd0;
    logic [31:0] dmem_address_o;
    logic        dmem_read_o;
    logic        dmem_write_o;
    logic [3:0]  dmem_mbe_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i = 32'd0;
    logic        dmem_resp_i = 1'b0;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        misalign_o;
    logic [31:0] load_cnt_o;
    logic [31:0] store_cnt_o;
    logic [31:0] stall_cnt_o;

    int tests = 0;
    int fails = 0;

    // Observations from the last access
    int          stall_seen;
    logic        hold_ok;
    logic [31:0] snap_addr;
    logic        snap_read;
    logic        snap_write;
    logic [3:0]  snap_mbe;
    logic [31:0] snap_wdata;

    always #5 clk = ~clk;

    mem_stage_dport #(.width(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .mem_read_i     (mem_read_i),
        .mem_write_i    (mem_write_i),
        .funct3_i       (funct3_i),
        .addr_i         (addr_i),
        .store_data_i   (store_data_i),
        .dmem_address_o (dmem_address_o),
        .dmem_read_o    (dmem_read_o),
        .dmem_write_o   (dmem_write_o),
        .dmem_mbe_o     (dmem_mbe_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_rdata_i   (dmem_rdata_i),
        .dmem_resp_i    (dmem_resp_i),
        .stall_o        (stall_o),
        .load_data_o    (load_data_o),
        .misalign_o     (misalign_o),
        .load_cnt_o     (load_cnt_o),
        .store_cnt_o    (store_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    // Issue one access from IDLE and respond after nbusy BUSY cycles; returns in DONE.
    // Non-handshake inputs are scrambled during BUSY to confirm they are ignored.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int nbusy, input logic [31:0] rdata);
        req_valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
        funct3_i = f3; addr_i = addr; store_data_i = wd;
        stall_seen = 0;
        #1;
        if (stall_o) stall_seen++;
        @(posedge clk); #1;
        snap_addr = dmem_address_o; snap_read = dmem_read_o; snap_write = dmem_write_o;
        snap_mbe = dmem_mbe_o; snap_wdata = dmem_wdata_o;
        hold_ok = 1'b1;
        addr_i = ~addr; store_data_i = ~wd; funct3_i = ~f3;
        for (int i = 0; i < nbusy; i++) begin
            if (stall_o) stall_seen++;
            if (dmem_address_o !== snap_addr || dmem_read_o !== snap_read ||
                dmem_write_o !== snap_write || dmem_mbe_o !== snap_mbe ||
                dmem_wdata_o !== snap_wdata) hold_ok = 1'b0;
            if (i == nbusy - 1) begin
                dmem_resp_i = 1'b1; dmem_rdata_i = rdata;
            end
            @(posedge clk); #1;
            dmem_resp_i = 1'b0;
        end
    endtask

    // Retire the instruction in DONE and move to the next IDLE cycle
    task automatic end_access();
        req_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        tests++; if (dmem_read_o !== 1'b0 || dmem_write_o !== 1'b0) begin fails++; $display("FAIL reset_rw: got %b%b expected 00", dmem_read_o, dmem_write_o); end
        tests++; if (dmem_address_o !== 32'd0 || dmem_wdata_o !== 32'd0) begin fails++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", dmem_address_o, dmem_wdata_o); end
        tests++; if (dmem_mbe_o !== 4'd0) begin fails++; $display("FAIL reset_mbe: got %b expected 0000", dmem_mbe_o); end
        tests++; if (stall_o !== 1'b0 || misalign_o !== 1'b0) begin fails++; $display("FAIL reset_stall_mis: got %b%b expected 00", stall_o, misalign_o); end
        tests++; if (load_data_o !== 32'd0) begin fails++; $display("FAIL reset_load_data: got %h expected 0", load_data_o); end
        tests++; if (load_cnt_o !== 32'd0 || store_cnt_o !== 32'd0 || stall_cnt_o !== 32'd0) begin fails++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", load_cnt_o, store_cnt_o, stall_cnt_o); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
        tests++; if (stall_seen !== 4) begin fails++; $display("FAIL lw_stall_cycles: got %0d expected 4", stall_seen); end
        tests++; if (snap_read !== 1'b1 || snap_write !== 1'b0) begin fails++; $display("FAIL lw_req: got r%b w%b expected r1 w0", snap_read, snap_write); end
        tests++; if (snap_addr !== 32'h100 || snap_mbe !== 4'hF) begin fails++; $display("FAIL lw_addr_mbe: got %h/%b expected 00000100/1111", snap_addr, snap_mbe); end
        tests++; if (hold_ok !== 1'b1) begin fails++; $display("FAIL lw_hold: got %b expected 1", hold_ok); end
        tests++; if (stall_o !== 1'b0 || dmem_read_o !== 1'b0) begin fails++; $display("FAIL lw_done_ctrl: got stall %b read %b expected 0 0", stall_o, dmem_read_o); end
        tests++; if (load_data_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_data: got %h expected deadbeef", load_data_o); end
        tests++; if (misalign_o !== 1'b0) begin fails++; $display("FAIL lw_misalign: got %b expected 0", misalign_o); end
        end_access();
    endtask

    task automatic test_stores();
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 2, 32'h0);
        tests++; if (snap_write !== 1'b1 || snap_read !== 1'b0) begin fails++; $display("FAIL sb_req: got r%b w%b expected r0 w1", snap_read, snap_write); end
        tests++; if (snap_mbe !== 4'b1000 || snap_wdata !== 32'hA5A5_A5A5) begin fails++; $display("FAIL sb_lanes: got %b/%h expected 1000/a5a5a5a5", snap_mbe, snap_wdata); end
        tests++; if (snap_addr !== 32'h200) begin fails++; $display("FAIL sb_addr: got %h expected 00000200", snap_addr); end
        tests++; if (hold_ok !== 1'b1) begin fails++; $display("FAIL sb_hold: got %b expected 1", hold_ok); end
        tests++; if (dmem_write_o !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL sb_done_ctrl: got write %b stall %b expected 0 0", dmem_write_o, stall_o); end
        end_access();
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 1, 32'h0);
        tests++; if (snap_mbe !== 4'b1100 || snap_wdata !== 32'hABCD_ABCD) begin fails++; $display("FAIL sh_lanes: got %b/%h expected 1100/abcdabcd", snap_mbe, snap_wdata); end
        end_access();
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_003C, 1, 32'h0);
        tests++; if (snap_mbe !== 4'b0010 || snap_wdata !== 32'h3C3C_3C3C) begin fails++; $display("FAIL sb1_lanes: got %b/%h expected 0010/3c3c3c3c", snap_mbe, snap_wdata); end
        end_access();
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'h8765_4321, 1, 32'h0);
        tests++; if (snap_mbe !== 4'b1111 || snap_wdata !== 32'h8765_4321 || snap_addr !== 32'h104) begin fails++; $display("FAIL sw_lanes: got %b/%h/%h expected 1111/87654321/00000104", snap_mbe, snap_wdata, snap_addr); end
        tests++; if (stall_seen !== 2) begin fails++; $display("FAIL sw_stall_cycles: got %0d expected 2", stall_seen); end
        end_access();
    endtask

    task automatic test_load_extend();
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h80FF_1234);
        tests++; if (load_data_o !== 32'hFFFF_80FF) begin fails++; $display("FAIL lh_sext: got %h expected ffff80ff", load_data_o); end
        end_access();
        run_access(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 1, 32'h80FF_1234);
        tests++; if (load_data_o !== 32'h0000_80FF) begin fails++; $display("FAIL lhu_zext: got %h expected 000080ff", load_data_o); end
        end_access();
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234);
        tests++; if (load_data_o !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb3_sext: got %h expected ffffff80", load_data_o); end
        tests++; if (misalign_o !== 1'b0) begin fails++; $display("FAIL lb_misalign: got %b expected 0", misalign_o); end
        end_access();
        run_access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234);
        tests++; if (load_data_o !== 32'h0000_0080) begin fails++; $display("FAIL lbu3_zext: got %h expected 00000080", load_data_o); end
        end_access();
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 1, 32'h80FF_1234);
        tests++; if (load_data_o !== 32'h0000_0012) begin fails++; $display("FAIL lb1: got %h expected 00000012", load_data_o); end
        end_access();
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0, 1, 32'h80FF_9234);
        tests++; if (load_data_o !== 32'hFFFF_9234) begin fails++; $display("FAIL lh0_sext: got %h expected ffff9234", load_data_o); end
        end_access();
        run_access(1'b1, 1'b0, 3'b011, 32'h0000_0102, 32'h0, 1, 32'hCAFE_F00D);
        tests++; if (load_data_o !== 32'hCAFE_F00D) begin fails++; $display("FAIL undef_raw: got %h expected cafef00d", load_data_o); end
        end_access();
    endtask

    task automatic test_misalign();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 1, 32'h1111_2222);
        tests++; if (misalign_o !== 1'b1) begin fails++; $display("FAIL lw_mis_flag: got %b expected 1", misalign_o); end
        tests++; if (snap_addr !== 32'h100 || snap_mbe !== 4'hF) begin fails++; $display("FAIL lw_mis_access: got %h/%b expected 00000100/1111", snap_addr, snap_mbe); end
        end_access();
        run_access(1'b1, 1'b0, 3'b101, 32'h0000_0103, 32'h0, 1, 32'h1111_2222);
        tests++; if (misalign_o !== 1'b1) begin fails++; $display("FAIL lhu_mis_flag: got %b expected 1", misalign_o); end
        end_access();
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h0);
        tests++; if (misalign_o !== 1'b0) begin fails++; $display("FAIL sh_aligned_flag: got %b expected 0", misalign_o); end
        end_access();
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h0, 1, 32'h0);
        tests++; if (misalign_o !== 1'b1) begin fails++; $display("FAIL sw_mis_flag: got %b expected 1", misalign_o); end
        end_access();
    endtask

    task automatic test_read_wins();
        run_access(1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h5555_5555, 1, 32'h0BAD_F00D);
        tests++; if (snap_read !== 1'b1 || snap_write !== 1'b0) begin fails++; $display("FAIL both_read_wins: got r%b w%b expected r1 w0", snap_read, snap_write); end
        tests++; if (load_data_o !== 32'h0BAD_F00D) begin fails++; $display("FAIL both_data: got %h expected 0badf00d", load_data_o); end
        end_access();
    endtask

    task automatic test_boundaries();
        // Response while IDLE must not be captured
        dmem_resp_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
        @(posedge clk); #1;
        dmem_resp_i = 1'b0;
        tests++; if (dmem_read_o !== 1'b0 || stall_o !== 1'b0 || load_data_o !== 32'h0BAD_F00D) begin fails++; $display("FAIL idle_resp: got r%b s%b d%h expected r0 s0 d0badf00d", dmem_read_o, stall_o, load_data_o); end
        // Non-memory instruction never stalls nor issues
        req_valid_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (stall_o !== 1'b0 || dmem_read_o !== 1'b0 || dmem_write_o !== 1'b0) begin fails++; $display("FAIL nonmem_cycle%0d: got s%b r%b w%b expected 000", i, stall_o, dmem_read_o, dmem_write_o); end
            @(posedge clk);
        end
        #1; req_valid_i = 1'b0;
        // Response while DONE must not overwrite the presented data
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 2, 32'hAAAA_0001);
        dmem_resp_i = 1'b1; dmem_rdata_i = 32'hBBBB_0002;
        end_access();
        dmem_resp_i = 1'b0;
        tests++; if (load_data_o !== 32'hAAAA_0001 || dmem_read_o !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL done_resp: got d%h r%b s%b expected daaaa0001 r0 s0", load_data_o, dmem_read_o, stall_o); end
    endtask

    task automatic test_rst_busy();
        req_valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h500;
        @(posedge clk); #1;
        tests++; if (dmem_read_o !== 1'b1) begin fails++; $display("FAIL rstb_issue: got %b expected 1", dmem_read_o); end
        #2;
        rst = 1'b1; req_valid_i = 1'b0; mem_read_i = 1'b0;
        #1;
        tests++; if (dmem_read_o !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL rstb_async: got r%b s%b expected r0 s0", dmem_read_o, stall_o); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        dmem_resp_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
        @(posedge clk); #1;
        dmem_resp_i = 1'b0;
        tests++; if (dmem_read_o !== 1'b0 || stall_o !== 1'b0 || load_data_o !== 32'd0) begin fails++; $display("FAIL rstb_late_resp: got r%b s%b d%h expected r0 s0 d00000000", dmem_read_o, stall_o, load_data_o); end
    endtask

    task automatic test_perf_cnt();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_access(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 1, 32'h1); end_access();
        run_access(1'b0, 1'b1, 3'b010, 32'h604, 32'h2, 1, 32'h0); end_access();
        run_access(1'b1, 1'b0, 3'b000, 32'h608, 32'h0, 1, 32'h3); end_access();
`ifdef MEM_STAGE_DPORT_PERF_CNT_EN
        tests++; if (load_cnt_o !== 32'd2) begin fails++; $display("FAIL perf_loads: got %0d expected 2", load_cnt_o); end
        tests++; if (store_cnt_o !== 32'd1) begin fails++; $display("FAIL perf_stores: got %0d expected 1", store_cnt_o); end
        tests++; if (stall_cnt_o !== 32'd6) begin fails++; $display("FAIL perf_stalls: got %0d expected 6", stall_cnt_o); end
`else
        tests++; if (load_cnt_o !== 32'd0 || store_cnt_o !== 32'd0 || stall_cnt_o !== 32'd0) begin fails++; $display("FAIL perf_tied_zero: got %0d/%0d/%0d expected 0/0/0", load_cnt_o, store_cnt_o, stall_cnt_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_lw();
        test_stores();
        test_load_extend();
        test_misalign();
        test_read_wins();
        test_boundaries();
        test_rst_busy();
        test_perf_cnt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

endmodule
